// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: four producers share one FIFO write port, never writing into a full FIFO.
// Define FIFO_ARB_BURST_EN to let an owner keep the FIFO for up to MAX_BURST consecutive writes.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] data,
    output logic [NREQ-1:0]    ack,
    output logic               fifo_w_en,
    output logic [DW-1:0]      fifo_data_in,
    input  logic               fifo_full,
    output logic               stall,
    output logic [15:0]        wr_count
);

    localparam int            PW        = $clog2(NREQ);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [3:0]    BURST_MAX = 4'(MAX_BURST);
`ifdef FIFO_ARB_BURST_EN
    localparam bit            BURST_EN  = 1'b1;
`else
    localparam bit            BURST_EN  = 1'b0;
`endif

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [PW-1:0]   owner, owner_n;
    logic [3:0]      burst_cnt, burst_cnt_n;
    logic            win_valid;
    logic [PW-1:0]   win_idx;
    logic            grant_valid;
    logic [PW-1:0]   grant_idx;

    // Search from the highest offset down so the requester closest to ptr is written last and wins.
    always_comb begin
        logic [PW-1:0] idx;
        win_valid = 1'b0;
        win_idx   = ptr;
        idx       = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr + PW'(k);
            if (req[idx]) begin
                win_valid = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path through this block infers a latch.
        state_n     = state;
        ptr_n       = ptr;
        owner_n     = owner;
        burst_cnt_n = burst_cnt;
        grant_valid = 1'b0;
        grant_idx   = owner;

        if (BURST_EN && state == BURST) begin
            if (req[owner] && !fifo_full && burst_cnt < BURST_MAX) begin
                grant_valid = 1'b1;
                burst_cnt_n = burst_cnt + 4'd1;
                if (burst_cnt_n == BURST_MAX) begin
                    ptr_n   = owner + PTR_ONE;
                    state_n = IDLE;
                end
            end else if (!req[owner]) begin
                // Owner released early: spend one bubble cycle handing priority to its neighbour.
                ptr_n   = owner + PTR_ONE;
                state_n = IDLE;
            end
        end else if (win_valid && !fifo_full) begin
            grant_valid = 1'b1;
            grant_idx   = win_idx;
            owner_n     = win_idx;
            burst_cnt_n = 4'd1;
            if (!BURST_EN || MAX_BURST == 1) begin
                ptr_n = win_idx + PTR_ONE;
            end else begin
                state_n = BURST;
            end
        end
    end

    // Gating with reset_n keeps the write port quiet for the whole reset, not just after the first edge.
    assign ack          = (grant_valid && reset_n) ? (NREQ'(1) << grant_idx) : '0;
    assign fifo_w_en    = |ack;
    assign fifo_data_in = fifo_w_en ? data[grant_idx*DW +: DW] : '0;

    // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            stall     <= 1'b0;
            wr_count  <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            owner     <= owner_n;
            burst_cnt <= burst_cnt_n;
            stall     <= (|req) & fifo_full;
            if (fifo_w_en) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter sharing one 8-entry × 8-bit FIFO among four producers. Selects at most one requester per cycle and drives the FIFO write port (`w_en`, `data_in`) directly. Observes FIFO `full` so no write is ever issued into a full FIFO. Sits between the producer blocks and the FIFO write side; the read side is untouched.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; fixed at 4 in this revision.
- `DW`, 8: data width; matches the FIFO.
- `MAX_BURST`, 4: maximum consecutive writes by one owner when bursting is compiled in; legal range 1–15.

Ports:
- `clk`  in  1  — single clock; all state changes on its rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `req`  in  4  — per-requester write request; held high with `data` stable until `ack`.
- `data`  in  32  — requester i data on bits `[8i+7:8i]`.
- `ack`  out  4  — one-hot or zero; `ack[i]`=1 means `data[i]` is written at this rising edge.
- `fifo_w_en`  out  1  — to FIFO `w_en`; equals `|ack`.
- `fifo_data_in`  out  8  — to FIFO `data_in`; equals `data` of the acked requester, otherwise 0.
- `fifo_full`  in  1  — from FIFO `full`.
- `stall`  out  1  — registered; 1 when the previous cycle had `|req` and `fifo_full`.
- `wr_count`  out  16  — registered count of accepted writes; wraps from 0xFFFF to 0.

## Operation
- State: rotating priority pointer `ptr` (2 bits), FSM {IDLE, BURST}, `owner` (2 bits), `burst_cnt` (4 bits), `stall`, `wr_count`.
- `ack`, `fifo_w_en` and `fifo_data_in` are combinational from `req`, `fifo_full` and the registered state. No write is ever issued while `fifo_full`=1.
- IDLE:
  - Winner is the first index with `req` set, searching `ptr`, `ptr+1`, … modulo 4.
  - If a winner exists and `!fifo_full`: assert `ack[winner]`, `owner`<=winner, `burst_cnt`<=1.
  - Without the burst feature, or with `MAX_BURST`=1: `ptr`<=winner+1 and stay in IDLE.
  - Otherwise go to BURST.
  - If there is no winner, or `fifo_full`=1: no ack; state, `ptr` and `owner` are unchanged.
- BURST (only `owner` may be granted):
  - `req[owner]`=1, `!fifo_full`, `burst_cnt`<`MAX_BURST`: ack owner, `burst_cnt`+1.
  - Reaching `MAX_BURST` with this write: `ptr`<=owner+1, go to IDLE.
  - `req[owner]`=1 and `fifo_full`: no ack, hold BURST and `burst_cnt`. Other requesters stay blocked.
  - `req[owner]`=0: no ack this cycle (one bubble), `ptr`<=owner+1, go to IDLE.
- `stall`<=`(|req) & fifo_full` every cycle.
- `wr_count`<=`wr_count`+1 on every cycle with `fifo_w_en`=1.
- A requester that keeps `req` high after an ack presents its next word and competes again. It is not re-acked for the same word.

## Timing
- Reset (`reset_n`=0, asynchronous): `ptr`=0, IDLE, `owner`=0, `burst_cnt`=0, `stall`=0, `wr_count`=0.
- During reset, `ack`=0, `fifo_w_en`=0 and `fifo_data_in`=0 regardless of `req`.
- Reset asserted mid-burst aborts the burst. After release, arbitration restarts at requester 0.
- Latency: zero. The ack and the FIFO write occur at the same edge for which `req` was sampled.
- Throughput: one write per cycle while the FIFO is not full.
- `fifo_full` falling: a write can occur in the same cycle.
- Simultaneous FIFO read and write at full: `full` is still 1, so no write. This costs one cycle and loses no data.
- `wr_count` and `stall` update one cycle after the event.

## Configuration
- `FIFO_ARB_BURST_EN` defined: IDLE/BURST FSM as above; the owner keeps the FIFO for up to `MAX_BURST` writes.
- `FIFO_ARB_BURST_EN` undefined: the FSM stays permanently in IDLE. The pointer rotates after every write (strict per-word round robin), and `burst_cnt`/`owner` are not used for grant decisions.

## Test plan
- Reset check: `reset_n`=0 with `req`=4'hF → `ack`=0, `fifo_w_en`=0, `wr_count`=0. Release → first ack goes to requester 0.
- Per-word round robin (macro off): `req`=4'hF held, FIFO not full, data words 0x10/0x20/0x30/0x40 → acks in order 0,1,2,3,0; `wr_count`=5 after 5 cycles.
- Burst (macro on, `MAX_BURST`=4): `req`=4'b0011 held → four acks to requester 0, then four to requester 1, with no bubble.
- Early drop (macro on): requester 2 owns the FIFO and drops `req` after 2 writes while `req[3]`=1 → one cycle with no ack, then requester 3 is acked.
- Full back-pressure: fill the FIFO to 8 entries with `req[1]`=1 → `ack`=0 and `stall`=1 the next cycle. A single FIFO read → exactly one ack to requester 1 and no overflow.
- Counter wrap: preload traffic so `wr_count`=0xFFFF, then one write → `wr_count`=0x0000.
